// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: byte stream handshake from the serial receiver to the keyboard/PIA logic
interface uart_rx_fifo_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  modport master (output rx_data, rx_valid, input rx_ready);
  modport slave  (input rx_data, rx_valid, output rx_ready);
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 serial receiver with FWFT byte FIFO and registered active-low CTS
module uart_rx_fifo #(
  parameter int CLK_FREQ   = 25000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 4,
  parameter int CTS_THRESH = 2
) (
  input  logic          clk25,
  input  logic          rst,
  input  logic          uart_rx,
  uart_rx_fifo_if.master rx,
  output logic          uart_cts,
  output logic          frame_err,
  output logic          overrun
);
  localparam int CPB  = CLK_FREQ / BAUD;
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(CPB);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int NW   = AW + 1;
  localparam logic [NW-1:0] FULL = NW'(FIFO_DEPTH);
  localparam logic [1:0] IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3;

  logic          rx_m, rx_s, armed;
  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    sh;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [NW-1:0] count, count_next;
  logic          tick_half, tick_bit, tick, stop_smp, push, pop, accept;

  assign tick_half  = cnt == CW'(HALF - 1);
  assign tick_bit   = cnt == CW'(CPB - 1);
  assign tick       = (state == START) ? tick_half : tick_bit;
  assign stop_smp   = state == STOP && tick_bit;
  assign push       = stop_smp && rx_s;
  assign pop        = rx.rx_valid && rx.rx_ready;
  assign accept     = push && (count < FULL || pop);
  assign count_next = count + NW'(accept) - NW'(pop);
  assign rx.rx_valid = count != '0;
  assign rx.rx_data  = rx.rx_valid ? mem[rp] : 8'h00;

  always_ff @(posedge clk25) begin
    if (rst) {rx_m, rx_s} <= 2'b11;
    else {rx_m, rx_s} <= {uart_rx, rx_m};
  end

  // armed only after a high sample in IDLE, so a held-low line cannot retrigger
  always_ff @(posedge clk25) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      sh        <= '0;
      armed     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= stop_smp && !rx_s;
      overrun   <= push && !accept;
      armed     <= state == IDLE && rx_s;
      cnt       <= (state == IDLE || tick) ? '0 : cnt + CW'(1);
      case (state)
        IDLE: begin
          bit_idx <= '0;
          if (armed && !rx_s) state <= START;
        end
        START: if (tick_half) state <= rx_s ? IDLE : DATA;
        DATA: if (tick_bit) begin
          sh      <= {rx_s, sh[7:1]};
          bit_idx <= bit_idx + 3'd1;
          if (bit_idx == 3'd7) state <= STOP;
        end
        STOP: if (tick_bit) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk25) begin
    if (accept) mem[wp] <= sh;
  end

  always_ff @(posedge clk25) begin
    if (rst) begin
      wp       <= '0;
      rp       <= '0;
      count    <= '0;
      uart_cts <= 1'b1;
    end else begin
      if (accept) wp <= wp + AW'(1);
      if (pop) rp <= rp + AW'(1);
      count    <= count_next;
      uart_cts <= count_next >= NW'(CTS_THRESH);
    end
  end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive side of the Apple 1 serial console: deserialises 8N1 async frames arriving on uart_rx from the host computer.
- Buffers received bytes in a small FIFO and presents them to the keyboard/PIA logic through a valid/ready handshake.
- Drives uart_cts for hardware flow control back to the host.
- Runs entirely in the clk25 domain.

Parameters:
CLK_FREQ, 25000000, clk25 frequency in Hz
BAUD, 115200, serial bit rate
FIFO_DEPTH, 4, byte entries in receive FIFO (power of 2, >=4)
CTS_THRESH, 2, FIFO count at or above which uart_cts deasserts

Ports:
clk25  input  1  system clock
rst  input  1  synchronous reset, active-high
uart_rx  input  1  asynchronous serial input, idle high
rx_data  output  8  byte at FIFO head
rx_valid  output  1  FIFO non-empty; rx_data valid
rx_ready  input  1  consumer accepts rx_data when rx_valid && rx_ready
uart_cts  output  1  active-low clear-to-send to host (0 = host may send)
frame_err  output  1  one-cycle pulse: stop bit sampled low
overrun  output  1  one-cycle pulse: completed byte dropped, FIFO full

Behaviour:
- One clock: clk25. Reset is synchronous, active-high (rst).
- Bit timing: CLKS_PER_BIT = CLK_FREQ/BAUD, integer-truncated (217 at defaults). HALF = CLKS_PER_BIT/2 (108).
- Input sync: uart_rx passes through a 2-flop synchroniser, both flops reset to 1. All decisions use the synchronised value rx_s.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: rx_s == 0 -> START, bit counter cleared.
  - START: after HALF clocks, re-sample rx_s. If 1, false start -> IDLE, no output. If 0 -> DATA.
  - DATA: sample every CLKS_PER_BIT, LSB first into a shift register; after the 8th sample -> STOP.
  - STOP: sample after CLKS_PER_BIT.
    - rx_s == 1: byte pushed to FIFO; if the push is refused, one-cycle overrun pulse and the byte is discarded.
    - rx_s == 0: one-cycle frame_err pulse, byte discarded.
    - Either way -> IDLE on the next cycle, at mid-stop-bit, so back-to-back frames are caught.
- FIFO:
  - First-word-fall-through: rx_data = head entry whenever rx_valid == 1.
  - Pop occurs when rx_valid && rx_ready.
  - Push is accepted when count < FIFO_DEPTH, or when count == FIFO_DEPTH and a pop happens the same cycle.
  - Simultaneous push and pop leaves count unchanged.
  - Pointers wrap modulo FIFO_DEPTH; count is log2(FIFO_DEPTH)+1 bits.
- Latency: the byte is written on the stop-sample cycle. rx_valid rises the following cycle when the FIFO was empty.
- Flow control: uart_cts is registered, = (count_next >= CTS_THRESH). This leaves headroom for bytes already in flight from the host.
- Reset values: rx_valid 0, rx_data 8'h00, frame_err 0, overrun 0, uart_cts 1 (not clear) while rst is held. FIFO emptied, FSM in IDLE.
  - uart_cts goes to 0 on the first cycle after rst deasserts.
  - rst mid-frame abandons the frame; no push, no pulses.
- A line held low continuously (break) yields frame_err once. The FSM then re-arms only after rx_s returns high and falls again; IDLE waits for a 1 before honouring a new 0.

Test Plan:
- Idle line, then frame 0x41 at 217 clk/bit -> rx_valid rises 1 cycle after stop sample, rx_data 0x41; pulse rx_ready -> rx_valid 0, uart_cts stays 0.
- Low glitch of 50 cycles on an idle line -> no rx_valid, no frame_err, FSM back in IDLE.
- Frame 0x55 with stop bit driven 0 -> frame_err single-cycle pulse, FIFO count 0. Then a valid 0xAA frame -> rx_data 0xAA.
- rx_ready=0, send 0x01..0x05 back-to-back (no idle gap):
  - uart_cts goes 1 after the 2nd byte is stored.
  - 4 bytes are stored; overrun pulses on the 5th.
  - Draining yields 0x01,0x02,0x03,0x04 in order; uart_cts returns to 0 when count < 2.
- FIFO full with rx_ready=1 asserted on the 5th byte's stop-sample cycle -> push accepted, no overrun, count stays 4.
- Assert rst for 1 cycle mid-DATA of frame 0x7E -> no rx_valid, uart_cts 1 during rst then 0. The next full frame 0x33 is received correctly.
